// File: rtl/mc_control_v2_if.sv
// Memory handshake bundle between the multi-cycle control unit and the shared memory.
//   mem_req             request active (driven by control)
//   mem_write           write strobe, valid only with mem_req (driven by control)
//   instruction_or_data 0 = address from PC, 1 = address from ALUOut (driven by control)
//   mem_ready           memory completes the current request this cycle (driven by memory)
interface mc_control_v2_if;
  logic mem_req;
  logic mem_write;
  logic instruction_or_data;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output instruction_or_data,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  instruction_or_data,
    output mem_ready
  );
endinterface

// File: rtl/mc_control_v2.sv
// Multi-cycle RV32I control FSM for the shared-memory datapath (PC, OldPC, IR, ALUOut, Data).
// Drives all datapath enables and muxes from the IR opcode/funct fields, with a
// variable-latency memory handshake, a memory-wait timeout and a sticky trap state.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   mem_bus             memory handshake (master side), see mc_control_v2_if
//   opcode_i/funct3_i/funct7_i  IR fields
//   alu_zero_i          combinational ALU result == 0
//   ir_write_o, pc_write_o, reg_write_o  datapath strobes
//   result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o, imm_src_o  datapath muxes
//   trap_o, trap_cause_o  sticky trap (01 illegal instruction, 10 bus timeout)
//   current_state_o     FSM state for debug
// Optional: define MC_CTRL_PERF_EN to add instret_o and stall_cycles_o counters.
module mc_control_v2 #(
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned TO_CNT_W    = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mc_control_v2_if.master       mem_bus,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic                  alu_zero_i,
  output logic                  ir_write_o,
  output logic                  pc_write_o,
  output logic                  reg_write_o,
  output logic [1:0]            result_src_o,
  output logic [1:0]            alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic [2:0]            imm_src_o,
  output logic                  trap_o,
  output logic [1:0]            trap_cause_o,
`ifdef MC_CTRL_PERF_EN
  output logic [CNT_W-1:0]      instret_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
`endif
  output logic [4:0]            current_state_o
);

  if (ALU_CTRL_W < 4) begin : g_chk_alu_w
    $error("ALU_CTRL_W must be at least 4");
  end
  if ((MEM_TIMEOUT >> TO_CNT_W) != 0) begin : g_chk_to_w
    $error("TO_CNT_W too narrow for MEM_TIMEOUT");
  end
  if (CNT_W < 1) begin : g_chk_cnt_w
    $error("CNT_W must be at least 1");
  end

  localparam logic [6:0] OpLoad = 7'b0000011, OpStore = 7'b0100011, OpR   = 7'b0110011,
                         OpI    = 7'b0010011, OpLui   = 7'b0110111, OpAuipc = 7'b0010111,
                         OpJal  = 7'b1101111, OpJalr  = 7'b1100111, OpBranch = 7'b1100011;
  localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluAnd = 4'd2, AluOr  = 4'd3,
                         AluXor = 4'd4, AluSlt = 4'd5, AluSltu = 4'd6, AluSll = 4'd7,
                         AluSrl = 4'd8, AluSra = 4'd9;
  localparam logic [1:0] CauseIllegal = 2'b01, CauseBus = 2'b10;

  typedef enum logic [4:0] {
    StFetch    = 5'd0,  StDecode   = 5'd1,  StMemAdr = 5'd2,  StMemRd  = 5'd3,
    StMemWr    = 5'd4,  StMemWb    = 5'd5,  StExecR  = 5'd6,  StExecI  = 5'd7,
    StExecU    = 5'd8,  StJal      = 5'd9,  StJalrAdr = 5'd10, StJalrLink = 5'd11,
    StAluWb    = 5'd12, StBranch   = 5'd13, StTrap   = 5'd14
  } state_e;

  state_e              state_q, state_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                trap_q, trap_d;
  logic [1:0]          cause_q, cause_d;

  logic       req, wr, iod, irw, pcw, rgw;
  logic [1:0] res_src, src_a, src_b;
  logic [3:0] alu_op;
  logic       mem_wait, to_hit, alt, f7_zero, r_legal, i_legal;

  // funct3 decode shared by R and I forms; SUB only exists in R form.
  function automatic logic [3:0] alu_funct(input logic [2:0] f3, input logic alt_op,
                                           input logic is_r);
    case (f3)
      3'b000:  return (alt_op && is_r) ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt_op ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  assign alt      = (funct7_i == 7'b0100000);
  assign f7_zero  = (funct7_i == 7'b0000000);
  assign r_legal  = f7_zero || (alt && (funct3_i == 3'b000 || funct3_i == 3'b101));
  assign i_legal  = !((funct3_i == 3'b001 && !f7_zero) ||
                      (funct3_i == 3'b101 && !(f7_zero || alt)));
  assign mem_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // Trap on the wait cycle whose increment would bring the count to MEM_TIMEOUT.
  assign to_hit   = (MEM_TIMEOUT != 0) && (to_cnt_q == TO_CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    req     = 1'b0;
    wr      = 1'b0;
    iod     = 1'b0;
    irw     = 1'b0;
    pcw     = 1'b0;
    rgw     = 1'b0;
    res_src = 2'b00;
    src_a   = 2'b00;
    src_b   = 2'b00;
    alu_op  = AluAdd;
    unique case (state_q)
      StFetch: begin
        req     = 1'b1;
        src_b   = 2'b01;
        res_src = 2'b10;
        if (mem_bus.mem_ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = StDecode;
        end else if (to_hit) begin
          state_d = StTrap;
          cause_d = CauseBus;
        end
      end
      StDecode: begin
        src_a = 2'b10;
        src_b = 2'b10;
        case (opcode_i)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpLui, OpAuipc:  state_d = StExecU;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalrAdr;
          OpBranch:        state_d = StBranch;
          default: begin
            state_d = StTrap;
            cause_d = CauseIllegal;
          end
        endcase
      end
      StMemAdr: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        state_d = opcode_i[5] ? StMemWr : StMemRd;  // bit 5 separates SW from LW
      end
      StMemRd, StMemWr: begin
        req = 1'b1;
        iod = 1'b1;
        wr  = (state_q == StMemWr);
        if (mem_bus.mem_ready) begin
          state_d = (state_q == StMemWr) ? StFetch : StMemWb;
        end else if (to_hit) begin
          state_d = StTrap;
          cause_d = CauseBus;
        end
      end
      StMemWb: begin
        res_src = 2'b01;
        rgw     = 1'b1;
        state_d = StFetch;
      end
      StExecR, StExecI: begin
        src_a   = 2'b01;
        src_b   = (state_q == StExecR) ? 2'b00 : 2'b10;
        alu_op  = alu_funct(funct3_i, alt, state_q == StExecR);
        if ((state_q == StExecR) ? r_legal : i_legal) begin
          state_d = StAluWb;
        end else begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end
      end
      StExecU: begin
        src_a   = opcode_i[5] ? 2'b11 : 2'b10;  // LUI adds to zero, AUIPC to OldPC
        src_b   = 2'b10;
        state_d = StAluWb;
      end
      StJal: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        pcw     = 1'b1;
        state_d = StAluWb;
      end
      StJalrAdr: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        res_src = 2'b10;
        if (funct3_i == 3'b000) begin
          pcw     = 1'b1;
          state_d = StJalrLink;
        end else begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end
      end
      StJalrLink: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = StAluWb;
      end
      StAluWb: begin
        rgw     = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        src_a   = 2'b01;
        state_d = StFetch;
        case (funct3_i[2:1])
          2'b00:   alu_op = AluSub;
          2'b10:   alu_op = AluSlt;
          2'b11:   alu_op = AluSltu;
          default: begin
            state_d = StTrap;
            cause_d = CauseIllegal;
          end
        endcase
        // BEQ/BGE/BGEU take on zero; BNE/BLT/BLTU take on non-zero.
        if (funct3_i[2:1] != 2'b01) pcw = alu_zero_i ^ (funct3_i[0] ^ funct3_i[2]);
      end
      StTrap: begin
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_d != state_q) to_cnt_d = '0;
    else if (mem_wait)      to_cnt_d = to_cnt_q + 1'b1;
  end

  assign trap_d = trap_q | (state_d == StTrap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StFetch;
      to_cnt_q <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    imm_src_o = 3'b000;
    case (opcode_i)
      OpStore:        imm_src_o = 3'b001;
      OpBranch:       imm_src_o = 3'b010;
      OpLui, OpAuipc: imm_src_o = 3'b011;
      OpJal:          imm_src_o = 3'b100;
      default:        imm_src_o = 3'b000;
    endcase
  end

  // Strobes are gated by reset_n so they drop the instant reset asserts.
  assign mem_bus.mem_req             = req & reset_n;
  assign mem_bus.mem_write           = wr & reset_n;
  assign mem_bus.instruction_or_data = iod;
  assign ir_write_o      = irw & reset_n;
  assign pc_write_o      = pcw & reset_n;
  assign reg_write_o     = rgw & reset_n;
  assign result_src_o    = res_src;
  assign alu_src_a_o     = src_a;
  assign alu_src_b_o     = src_b;
  assign alu_control_o   = ALU_CTRL_W'(alu_op);
  assign trap_o          = trap_q;
  assign trap_cause_o    = cause_q;
  assign current_state_o = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] instret_q, stall_q;
  logic             retire;

  assign retire = (state_d == StFetch) &&
                  ((state_q == StMemWb) || (state_q == StMemWr) ||
                   (state_q == StAluWb) || (state_q == StBranch));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire)                         instret_q <= instret_q + 1'b1;
      if (mem_wait && !mem_bus.mem_ready) stall_q   <= stall_q + 1'b1;
    end
  end

  assign instret_o      = instret_q;
  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: doc/mc_control_v2.md
Name: mc_control_v2

Overview:
- Multi-cycle RV32I control FSM for the shared-memory datapath (PC, OldPC, IR, ALUOut, Data registers).
- Next generation of the multi-cycle control unit. It adds a variable-latency memory handshake, full RV32I ALU decode, branch/JAL/JALR/LUI/AUIPC sequencing, and a sticky trap state.
- It sits between the IR opcode/funct fields and all datapath enables and muxes.

Parameters:
- ALU_CTRL_W, 4: alu_control width; must be ≥4.
- MEM_TIMEOUT, 64: maximum cycles in a memory-wait state before a bus-error trap; 0 disables the timeout.
- TO_CNT_W, 8: width of the timeout counter; must satisfy 2^TO_CNT_W > MEM_TIMEOUT.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- alu_zero  in  1  ALU result == 0, from the combinational ALU output.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access active.
- mem_write  out  1  write strobe; valid only with mem_req.
- instruction_or_data  out  1  0 = address from PC, 1 = address from ALUOut.
- ir_write  out  1  load IR and OldPC.
- pc_write  out  1  load PC from the result mux.
- reg_write  out  1  register-file write.
- result_src  out  2  00 ALUOut, 01 Data, 10 ALU result direct.
- alu_src_a  out  2  00 PC, 01 rs1, 10 OldPC, 11 zero.
- alu_src_b  out  2  00 rs2, 01 const 4, 10 imm.
- alu_control  out  ALU_CTRL_W  operation code (encoding below).
- imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J. Combinational from opcode in every state.
- trap  out  1  sticky trap indication.
- trap_cause  out  2  01 illegal instruction, 10 bus timeout.
- current_state  out  5  FSM state, for debug.

Behaviour:
- Reset: async on reset_n low → state FETCH, timeout counter 0, trap 0, trap_cause 00. All strobes (mem_write, reg_write, ir_write, pc_write) are 0 during reset.
  - Outputs are combinational from state and inputs. Default for every output is 0 unless listed below.
- ALU encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
- FETCH:
  - mem_req=1, instruction_or_data=0, alu_src_a=00, alu_src_b=01, ADD, result_src=10.
  - ir_write and pc_write assert only in the cycle mem_ready=1; the FSM then goes to DECODE, otherwise it holds in FETCH.
- DECODE:
  - alu_src_a=10, alu_src_b=10, ADD. ALUOut receives OldPC+imm (the branch/JAL target).
  - Next state by opcode:
    - LW/SW → MEM_ADR
    - R → EXEC_R
    - I-ALU → EXEC_I
    - LUI/AUIPC → EXEC_U
    - JAL → JAL
    - JALR → JALR_ADR
    - B → BRANCH
    - any other opcode → TRAP (cause 01)
- MEM_ADR: alu_src_a=01, alu_src_b=10, ADD. LW → MEM_RD, SW → MEM_WR.
- MEM_RD: mem_req=1, instruction_or_data=1. Holds until mem_ready, then → MEM_WB.
- MEM_WR: mem_req=1, mem_write=1, instruction_or_data=1. Holds until mem_ready, then → FETCH.
- MEM_WB: result_src=01, reg_write=1 → FETCH.
- EXEC_R: alu_src_a=01, alu_src_b=00, op from funct3.
  - funct7 other than 0000000 or 0100000 → TRAP (cause 01).
  - funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - Otherwise → ALU_WB.
- EXEC_I: alu_src_a=01, alu_src_b=10, op from funct3.
  - 001 (SLLI) requires funct7=0.
  - 101 (SRLI/SRAI) requires funct7 ∈ {0, 0100000}; else TRAP (cause 01).
  - funct7 is ignored for all other funct3 values.
- EXEC_U: alu_src_b=10, ADD; alu_src_a=11 for LUI, 10 for AUIPC → ALU_WB.
- JAL: alu_src_a=10, alu_src_b=01, ADD, result_src=00, pc_write=1 (PC ← target) → ALU_WB (rd ← OldPC+4).
- JALR_ADR: alu_src_a=01, alu_src_b=10, ADD, result_src=10, pc_write=1. funct3≠000 → TRAP (cause 01) with pc_write=0. Otherwise → JALR_LINK.
- JALR_LINK: alu_src_a=10, alu_src_b=01, ADD → ALU_WB.
- ALU_WB: result_src=00, reg_write=1 → FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, result_src=00 → FETCH.
  - funct3 000/001 use SUB; 100/101 use SLT; 110/111 use SLTU. 010/011 → TRAP (cause 01).
  - pc_write = taken:
    - BEQ: taken = alu_zero
    - BNE: taken = !alu_zero
    - BLT/BLTU: taken = !alu_zero
    - BGE/BGEU: taken = alu_zero
- Timeout:
  - The counter clears on entering FETCH, MEM_RD or MEM_WR and increments each cycle the FSM stays in those states with mem_ready=0.
  - When the count reaches MEM_TIMEOUT (MEM_TIMEOUT>0) → TRAP (cause 10), with mem_req deasserted from the next cycle.
  - mem_ready in the same cycle the limit is reached wins: the access completes and there is no trap.
- TRAP: all strobes 0 and trap=1. Exit only via reset_n.
- Reset mid-access: all strobes and mem_req drop immediately (async); the FSM restarts in FETCH.
- Latency with mem_ready tied 1, in cycles: R/I/U 4, LW 5, SW 4, BRANCH 3, JAL 4, JALR 5.

Optional Feature:
- MC_CTRL_PERF_EN defined: adds outputs instret (CNT_W) and stall_cycles (CNT_W). Both reset to 0 and wrap modulo 2^CNT_W.
  - instret increments on each transition into FETCH from MEM_WB, MEM_WR, ALU_WB or BRANCH.
  - stall_cycles increments on each memory-wait cycle with mem_ready=0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- ADD x3,x1,x2 with mem_ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB; alu_control=0; reg_write=1 only in cycle 4.
- LW with mem_ready delayed 3 cycles in MEM_RD → mem_req high 4 cycles, instruction_or_data=1, reg_write in MEM_WB; total 8 cycles.
- BNE with alu_zero=1, then BNE with alu_zero=0 → pc_write=0 in BRANCH, then pc_write=1 in BRANCH; alu_control=1 in both.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → TRAP after 4 wait cycles, trap_cause=10, ir_write never asserted; reset_n low → FETCH, trap=0.
- opcode 7'b1111111 → TRAP from DECODE with cause 01. funct7=0100000 with funct3=100 (R-type) → TRAP from EXEC_R with reg_write never asserted.
- MC_CTRL_PERF_EN: ADD, SW and BEQ-taken back to back with mem_ready=1 → instret=3 and stall_cycles=0 after 11 cycles.
